// File: rtl/morse_timing_calibrator.sv
// Morse timing calibrator: measures N_CAL operator dits and
// publishes averaged dit/dah/word/tol timings to the decoder.
module morse_timing_calibrator #(
  parameter int PULSE_CNT_W = 24,
  parameter int N_CAL       = 4,
  parameter int DEF_DIT     = 2500000,
  parameter int MIN_PULSE   = 50000,
  parameter int TIMEOUT     = 100000000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ce,
  input  logic                   start,
  input  logic                   signal,
  output logic [PULSE_CNT_W-1:0] dit_time,
  output logic [PULSE_CNT_W-1:0] dah_time,
  output logic [PULSE_CNT_W-1:0] word_time,
  output logic [PULSE_CNT_W-1:0] tol_time,
  output logic                   ready,
  output logic                   busy,
  output logic                   cal_error
);

  localparam int W  = PULSE_CNT_W;
  localparam int LG = $clog2(N_CAL);
  localparam int SW = W + LG;
  localparam int CW = LG + 1;
  localparam int XW = W + 3;

  localparam logic [W-1:0] DEF_D  = W'(DEF_DIT);
  localparam logic [W-1:0] DEF_DH = W'(3 * DEF_DIT);
  localparam logic [W-1:0] DEF_W  = W'(7 * DEF_DIT);
  localparam logic [W-1:0] DEF_T  = W'(DEF_DIT / 2);
  localparam logic [W-1:0] TO_M1  = W'(TIMEOUT - 1);
  localparam logic [W-1:0] MINP   = W'(MIN_PULSE);
  localparam logic [CW-1:0] LAST  = CW'(N_CAL - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_WAIT, S_PRESS,
    S_COMP, S_APPLY, S_ABORT
  } state_e;

  state_e        state_q, state_d;
  logic          s1_q, s2_q;
  logic [W-1:0]  timer_q, timer_d;
  logic [SW-1:0] sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  dit_q, dit_d, dah_q, dah_d;
  logic [W-1:0]  wrd_q, wrd_d, tol_q, tol_d;
  logic [W-1:0]  pdit_q, pdit_d, pdah_q, pdah_d;
  logic [W-1:0]  pwrd_q, pwrd_d, ptol_q, ptol_d;
  logic          rdy_q, rdy_d, busy_q, busy_d;
  logic          err_q, err_d;

  logic [W-1:0]  timer_inc;
  logic [XW-1:0] avg, dah_x, wrd_x, tol_x;

  // Staged averaging arithmetic, widened to catch word overflow.
  always_comb begin
    avg   = XW'(sum_q >> LG);
    dah_x = (avg << 1) + avg;
    wrd_x = (avg << 3) - avg;
    tol_x = avg >> 1;
    timer_inc = (&timer_q) ? timer_q : timer_q + 1'b1;
  end

  // Next-state and datapath update for the calibration sequence.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    dit_d   = dit_q;
    dah_d   = dah_q;
    wrd_d   = wrd_q;
    tol_d   = tol_q;
    pdit_d  = pdit_q;
    pdah_d  = pdah_q;
    pwrd_d  = pwrd_q;
    ptol_d  = ptol_q;
    rdy_d   = rdy_q;
    busy_d  = busy_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ARM;
          rdy_d   = 1'b0;
          busy_d  = 1'b1;
          err_d   = 1'b0;
          sum_d   = '0;
          cnt_d   = '0;
          timer_d = '0;
        end
      end
      S_ARM: begin
        if (s2_q) begin
          state_d = S_WAIT;
          timer_d = '0;
        end
      end
      S_WAIT: begin
        if (!s2_q) begin
          state_d = S_PRESS;
          timer_d = W'(1);
        end else if (timer_q == TO_M1) begin
          state_d = S_ABORT;
        end else begin
          timer_d = timer_inc;
        end
      end
      S_PRESS: begin
        if (s2_q) begin
          timer_d = '0;
          state_d = S_WAIT;
          if (timer_q >= MINP) begin
            sum_d = sum_q + SW'(timer_q);
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) state_d = S_COMP;
          end
        end else if (timer_q == TO_M1) begin
          state_d = S_ABORT;
        end else begin
          timer_d = timer_inc;
        end
      end
      S_COMP: begin
        pdit_d  = avg[W-1:0];
        pdah_d  = dah_x[W-1:0];
        pwrd_d  = wrd_x[W-1:0];
        ptol_d  = tol_x[W-1:0];
        state_d = (|wrd_x[XW-1:W]) ? S_ABORT : S_APPLY;
      end
      S_APPLY: begin
        dit_d   = pdit_q;
        dah_d   = pdah_q;
        wrd_d   = pwrd_q;
        tol_d   = ptol_q;
        rdy_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_ABORT: begin
        err_d   = 1'b1;
        rdy_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, synchroniser and timing set; ce=0 freezes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      timer_q <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      dit_q   <= DEF_D;
      dah_q   <= DEF_DH;
      wrd_q   <= DEF_W;
      tol_q   <= DEF_T;
      pdit_q  <= '0;
      pdah_q  <= '0;
      pwrd_q  <= '0;
      ptol_q  <= '0;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (ce) begin
      state_q <= state_d;
      s1_q    <= signal;
      s2_q    <= s1_q;
      timer_q <= timer_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      dit_q   <= dit_d;
      dah_q   <= dah_d;
      wrd_q   <= wrd_d;
      tol_q   <= tol_d;
      pdit_q  <= pdit_d;
      pdah_q  <= pdah_d;
      pwrd_q  <= pwrd_d;
      ptol_q  <= ptol_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign dit_time  = dit_q;
  assign dah_time  = dah_q;
  assign word_time = wrd_q;
  assign tol_time  = tol_q;
  assign ready     = rdy_q;
  assign busy      = busy_q;
  assign cal_error = err_q;

endmodule

// File: tb/tb_morse_timing_calibrator.sv
// Bench for morse_timing_calibrator: scoreboard of expected
// timing sets, popped whenever ready rises after a calibration.
module tb_morse_timing_calibrator;

  localparam int W  = 24;
  localparam int WB = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce = 1'b1;
  logic start_a = 1'b0, sig_a = 1'b1;
  logic start_b = 1'b0, sig_b = 1'b1;

  logic [W-1:0]  dit_a, dah_a, wrd_a, tol_a;
  logic          rdy_a, busy_a, err_a;
  logic [WB-1:0] dit_b, dah_b, wrd_b, tol_b;
  logic          rdy_b, busy_b, err_b;

  morse_timing_calibrator #(
    .PULSE_CNT_W(W), .N_CAL(4), .DEF_DIT(500),
    .MIN_PULSE(10), .TIMEOUT(20000)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .start(start_a), .signal(sig_a),
    .dit_time(dit_a), .dah_time(dah_a),
    .word_time(wrd_a), .tol_time(tol_a),
    .ready(rdy_a), .busy(busy_a), .cal_error(err_a)
  );

  morse_timing_calibrator #(
    .PULSE_CNT_W(WB), .N_CAL(4), .DEF_DIT(500),
    .MIN_PULSE(10), .TIMEOUT(20000)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .start(start_b), .signal(sig_b),
    .dit_time(dit_b), .dah_time(dah_b),
    .word_time(wrd_b), .tol_time(tol_b),
    .ready(rdy_b), .busy(busy_b), .cal_error(err_b)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] dit;
    logic [W-1:0] dah;
    logic [W-1:0] wrd;
    logic [W-1:0] tol;
    logic         err;
  } exp_t;

  exp_t sb_q[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int d, input bit e);
    exp_t x;
    x.dit = W'(d);
    x.dah = W'(3 * d);
    x.wrd = W'(7 * d);
    x.tol = W'(d / 2);
    x.err = e;
    sb_q.push_back(x);
  endtask

  task automatic start_cal_a();
    start_a = 1'b1;
    cyc(1);
    start_a = 1'b0;
  endtask

  task automatic press_a(input int lo, input int hi);
    sig_a = 1'b0;
    cyc(lo);
    sig_a = 1'b1;
    cyc(hi);
  endtask

  task automatic press_b(input int lo, input int hi);
    sig_b = 1'b0;
    cyc(lo);
    sig_b = 1'b1;
    cyc(hi);
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < budget) begin
      cyc(1);
      k++;
    end
    cyc(1);
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic chk_set_a(input string tag, input int d);
    chk({tag, "_dit"}, 32'(dit_a), 32'(d));
    chk({tag, "_dah"}, 32'(dah_a), 32'(3 * d));
    chk({tag, "_word"}, 32'(wrd_a), 32'(7 * d));
    chk({tag, "_tol"}, 32'(tol_a), 32'(d / 2));
  endtask

  // Pops one expected set per completed calibration of instance A.
  logic prev_rdy = 1'b1;
  exp_t e;
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && rdy_a && !prev_rdy) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("sb_dit", 32'(dit_a), 32'(e.dit));
          chk("sb_dah", 32'(dah_a), 32'(e.dah));
          chk("sb_word", 32'(wrd_a), 32'(e.wrd));
          chk("sb_tol", 32'(tol_a), 32'(e.tol));
          chk("sb_err", 32'(err_a), 32'(e.err));
          chk("sb_busy", 32'(busy_a), 32'd0);
        end
      end
      prev_rdy = rdy_a;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    cyc(3);
    rst_n = 1'b1;
    cyc(10);

    // Reset defaults
    chk_set_a("rst", 500);
    chk("rst_ready", 32'(rdy_a), 32'd1);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_err", 32'(err_a), 32'd0);
    chk("rst_b_word", 32'(wrd_b), 32'd3500);

    // Plain calibration, with a stray start mid-run
    push(1000, 1'b0);
    start_cal_a();
    cyc(5);
    chk("run_busy", 32'(busy_a), 32'd1);
    chk("run_ready", 32'(rdy_a), 32'd0);
    press_a(1000, 1000);
    press_a(1000, 500);
    start_cal_a();
    cyc(499);
    chk("run_busy2", 32'(busy_a), 32'd1);
    press_a(1000, 1000);
    press_a(1000, 1000);
    wait_done(200);
    chk_set_a("cal1", 1000);
    chk("cal1_ready", 32'(rdy_a), 32'd1);

    // Glitch among presses is discarded
    push(1001, 1'b0);
    start_cal_a();
    cyc(20);
    press_a(1000, 100);
    press_a(5, 100);
    press_a(1002, 100);
    press_a(998, 100);
    press_a(1004, 100);
    wait_done(200);
    chk_set_a("glitch", 1001);

    // Timeout abort keeps the set, flags error
    push(1001, 1'b1);
    start_cal_a();
    cyc(20);
    press_a(1000, 100);
    press_a(1000, 100);
    wait_done(21000);
    chk("to_err", 32'(err_a), 32'd1);
    chk("to_ready", 32'(rdy_a), 32'd1);
    chk_set_a("to", 1001);

    // Restart clears error; ce=0 pauses timing
    push(800, 1'b0);
    start_cal_a();
    cyc(3);
    chk("restart_err", 32'(err_a), 32'd0);
    chk("restart_busy", 32'(busy_a), 32'd1);
    press_a(800, 100);
    sig_a = 1'b0;
    cyc(400);
    ce = 1'b0;
    cyc(50);
    ce = 1'b1;
    cyc(400);
    sig_a = 1'b1;
    cyc(100);
    press_a(800, 100);
    press_a(800, 100);
    wait_done(200);
    chk_set_a("ce", 800);

    // Narrow instance: word overflow aborts
    start_b = 1'b1;
    cyc(1);
    start_b = 1'b0;
    cyc(10);
    chk("b_busy", 32'(busy_b), 32'd1);
    for (int i = 0; i < 4; i++) press_b(1000, 100);
    k = 0;
    while (!rdy_b && k < 200) begin
      cyc(1);
      k++;
    end
    chk("b_ready", 32'(rdy_b), 32'd1);
    chk("b_err", 32'(err_b), 32'd1);
    chk("b_dit", 32'(dit_b), 32'd500);
    chk("b_dah", 32'(dah_b), 32'd1500);
    chk("b_word", 32'(wrd_b), 32'd3500);
    chk("b_tol", 32'(tol_b), 32'd250);

    // Reset mid-press restores defaults
    start_cal_a();
    cyc(10);
    press_a(1000, 100);
    press_a(1000, 100);
    sig_a = 1'b0;
    cyc(500);
    rst_n = 1'b0;
    cyc(2);
    chk_set_a("mrst", 500);
    chk("mrst_busy", 32'(busy_a), 32'd0);
    chk("mrst_ready", 32'(rdy_a), 32'd1);
    sig_a = 1'b1;
    rst_n = 1'b1;
    cyc(10);
    chk("post_dit", 32'(dit_a), 32'd500);
    chk("post_busy", 32'(busy_a), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
